// File: rtl/mem_responder_if.sv
// Valid-ready memory port shared by IFU/LSU initiators and the memory responder.
// master = initiator side, slave = memory side.
interface mem_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_wen;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [3:0]       req_wmask;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding request, fixed (or LFSR-jittered)
// latency, word-addressed on-chip array behind a valid-ready port.
// Optional feature: define RANDOM_DELAY_EN to add 0..7 cycles of pseudo-random
// delay per request (8-bit LFSR x^8+x^6+x^5+x^4+1, seed 8'hA5).
module mem_responder #(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic clk,
  input  logic rst,
  mem_if.slave bus
);
  localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             wen_q;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic [3:0]       wmask_q;
  logic [31:0]      cnt, delay;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept, access, in_range;
  logic [31:0]      offset;
  logic [AW-1:0]    idx;

  assign accept   = bus.req_valid && (state == IDLE);
  assign access   = (state == WAIT) && (cnt == '0);
  // Unsigned offset: addresses below BASE_ADDR wrap high and land out of range.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign idx      = offset[AW+1:2];

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

`ifdef RANDOM_DELAY_EN
  logic [7:0] lfsr;

  // Free-running LFSR; its low bits at the accept edge pick the extra delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign delay = 32'(LATENCY) + {29'd0, lfsr[2:0]};
`else
  assign delay = 32'(LATENCY);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: IDLE -> WAIT on accept, WAIT -> RESP when the counter expires,
  // RESP -> IDLE on response handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, delay countdown and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      wen_q   <= bus.req_wen;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      wmask_q <= bus.req_wmask;
      cnt     <= delay - 32'd1;
    end else if (state == WAIT) begin
      if (cnt != '0) begin
        cnt <= cnt - 32'd1;
      end else begin
        rdata_q <= (in_range && !wen_q) ? mem[idx] : '0;
        err_q   <= !in_range;
      end
    end
  end

  // Array write; no reset so contents survive a responder reset. A reset
  // during WAIT forces IDLE asynchronously, so the pending write never lands.
  always_ff @(posedge clk) begin
    if (access && in_range && wen_q) begin
      for (int i = 0; i < 4; i++)
        if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, masked writes, range errors,
// response back-pressure, reset during WAIT, and (with RANDOM_DELAY_EN)
// jittered delay coverage.
module tb_mem_responder;
  localparam int          LAT   = 2;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_if #(.WIDTH(32)) bus ();

  mem_responder #(
    .WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit seen [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask);
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = mask;
  endtask

  // Drop valid and scramble the fields: the responder must have latched them.
  task automatic scramble_req();
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_wmask = 4'($urandom);
  endtask

  // Called #1 after the accept edge; waits for resp_valid and checks it.
  task automatic wait_resp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
    int lat = 0;
    while (!bus.resp_valid && lat < 40) begin
      step();
      lat++;
    end
`ifdef RANDOM_DELAY_EN
    chk({tag, "_lat_range"}, 32'(lat >= LAT && lat <= LAT + 7), 32'd1);
    if (lat >= LAT && lat <= LAT + 7) seen[lat - LAT] = 1'b1;
`else
    chk({tag, "_lat"}, 32'(lat), 32'(LAT));
`endif
    chk({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    chk({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
  endtask

  task automatic xact(input string tag, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask,
                      input logic [31:0] exp_rdata, input logic exp_err, input logic early);
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
    drive_req(wen, addr, wdata, mask);
    bus.resp_ready = early;
    step();
    scramble_req();
    wait_resp(tag, exp_rdata, exp_err);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    chk({tag, "_done"}, 32'(bus.resp_valid), 32'd0);
  endtask

  function automatic logic [31:0] pat(input int k);
    return 32'hA5A5_0000 | (32'(k) * 32'h0000_0101);
  endfunction

  initial begin
    int nrd;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wmask  = '0;
    bus.resp_ready = 1'b0;
    #2;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    step();
    step();
    rst = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Full-word write then read back.
    xact("wr0", 1'b1, BASE, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, 1'b0);
    xact("rd0", 1'b0, BASE, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Byte-lane merge.
    xact("wr1", 1'b1, BASE + 4, 32'h1122_3344, 4'hF, 32'd0, 1'b0, 1'b0);
    xact("wr1m", 1'b1, BASE + 4, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0, 1'b0);
    xact("rd1", 1'b0, BASE + 4, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b0);
    xact("wr1z", 1'b1, BASE + 4, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0, 1'b0);
    xact("rd1z", 1'b0, BASE + 4, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b0);

    // Range boundaries; resp_ready held early on one of them is harmless.
    xact("rd_below", 1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 32'd0, 1'b1, 1'b1);
    xact("rd_above", 1'b0, BASE + 4 * DEPTH, 32'd0, 4'h0, 32'd0, 1'b1, 1'b0);
    xact("wr_above", 1'b1, BASE + 4 * DEPTH, 32'h1234_5678, 4'hF, 32'd0, 1'b1, 1'b0);
    xact("wr_last", 1'b1, BASE + 4 * (DEPTH - 1), 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0, 1'b0);
    xact("rd_last", 1'b0, BASE + 4 * (DEPTH - 1), 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
    xact("rd0_kept", 1'b0, BASE, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Back-pressure: hold response 5 cycles with a competing request pending.
    chk("bp_rdy", 32'(bus.req_ready), 32'd1);
    drive_req(1'b0, BASE, 32'd0, 4'h0);
    step();
    scramble_req();
    wait_resp("bp", 32'hDEAD_BEEF, 1'b0);
    drive_req(1'b0, BASE + 4, 32'd0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_hold_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    chk("bp_done_valid", 32'(bus.resp_valid), 32'd0);
    chk("bp_done_ready", 32'(bus.req_ready), 32'd1);
    step();
    scramble_req();
    wait_resp("bp_next", 32'h11BB_33DD, 1'b0);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;

    // Reset while a write is in WAIT.
    xact("wr3", 1'b1, BASE + 12, 32'h0102_0304, 4'hF, 32'd0, 1'b0, 1'b0);
    xact("rd3", 1'b0, BASE + 12, 32'd0, 4'h0, 32'h0102_0304, 1'b0, 1'b0);
    drive_req(1'b1, BASE + 12, 32'h5555_5555, 4'hF);
    step();
    scramble_req();
    chk("rw_wait", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rw_valid", 32'(bus.resp_valid), 32'd0);
    chk("rw_rdata", bus.resp_rdata, 32'd0);
    chk("rw_err", 32'(bus.resp_err), 32'd0);
    step();
    step();
    rst = 1'b0;
    chk("rw_ready", 32'(bus.req_ready), 32'd1);
    xact("rd3_kept", 1'b0, BASE + 12, 32'd0, 4'h0, 32'h0102_0304, 1'b0, 1'b0);

    // Read sweep over a known pattern; under RANDOM_DELAY_EN it covers all delays.
    for (int k = 0; k < 8; k++)
      xact("pat_wr", 1'b1, BASE + 32'(4 * (16 + k)), pat(k), 4'hF, 32'd0, 1'b0, 1'b0);
`ifdef RANDOM_DELAY_EN
    nrd = 100;
`else
    nrd = 12;
`endif
    for (int i = 0; i < nrd; i++) begin
      int k;
      k = int'($urandom_range(0, 7));
      xact("pat_rd", 1'b0, BASE + 32'(4 * (16 + k)), 32'd0, 4'h0, pat(k), 1'b0, 1'b0);
    end
`ifdef RANDOM_DELAY_EN
    for (int d = 0; d < 8; d++)
      chk("delay_seen", 32'(seen[d]), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
